// File: rtl/instr_fetch.sv
// instr_fetch: two-word instruction fetch engine.
// Reads the opcode word (instr_addr1) and the immediate/next word
// (instr_addr2) from a single-port memory over a mem_rd/mem_ack handshake
// and presents them as instr/N with a one-cycle fetch_valid pulse.
// A read that waits TIMEOUT cycles without mem_ack is abandoned. The fetch
// then completes with instr=STP_WORD, N=0 and fetch_err=1, so the core halts.
// Optional feature: define FETCH_REUSE_EN to enable a one-entry reuse tag.
// The tag remembers the last fetched second word. When a new request's
// opcode address matches it, the opcode word is taken from the tag and only
// one memory read is performed.

module instr_fetch #(
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5,
  parameter logic [15:0] STP_WORD = 16'hF800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [15:0] instr_addr1,
  input  logic [15:0] instr_addr2,
  output logic        fetch_busy,
  output logic        fetch_valid,
  output logic [15:0] instr,
  output logic [15:0] N,
  output logic        fetch_err,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD1  = 2'd1;
  localparam logic [1:0] S_RD2  = 2'd2;

  // last counter value before a silent read is abandoned
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_r;
  logic [15:0]      a2_r;
  logic [CNT_W-1:0] cnt_r;
  logic             expire_s;

`ifdef FETCH_REUSE_EN
  logic [15:0] last_a2_r;
  logic [15:0] last_n_r;
  logic        tag_v_r;
  logic        reuse_hit_s;
`endif

  // timeout decode: the counter is at its limit and no ack came this cycle
  always_comb begin
    expire_s = 1'b0;
    if ((cnt_r == CNT_LAST) && !mem_ack) begin
      expire_s = 1'b1;
    end else begin
      expire_s = 1'b0;
    end
  end

`ifdef FETCH_REUSE_EN
  // reuse hit: the requested opcode address is the word fetched last as N
  always_comb begin
    reuse_hit_s = 1'b0;
    if (tag_v_r && (instr_addr1 == last_a2_r)) begin
      reuse_hit_s = 1'b1;
    end else begin
      reuse_hit_s = 1'b0;
    end
  end
`endif

  // fetch FSM, memory strobe, wait counter and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= S_IDLE;
      a2_r        <= 16'h0000;
      cnt_r       <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= 16'h0000;
      instr       <= 16'h0000;
      N           <= 16'h0000;
      fetch_valid <= 1'b0;
      fetch_busy  <= 1'b0;
      fetch_err   <= 1'b0;
`ifdef FETCH_REUSE_EN
      last_a2_r   <= 16'h0000;
      last_n_r    <= 16'h0000;
      tag_v_r     <= 1'b0;
`endif
    end else begin
      fetch_valid <= 1'b0;
      case (state_r)
        S_IDLE: begin
          // a stray mem_ack here is ignored: only fetch_req matters
          if (fetch_req) begin
            a2_r       <= instr_addr2;
            fetch_err  <= 1'b0;
            fetch_busy <= 1'b1;
            mem_rd     <= 1'b1;
            cnt_r      <= '0;
`ifdef FETCH_REUSE_EN
            if (reuse_hit_s) begin
              instr    <= last_n_r;
              mem_addr <= instr_addr2;
              state_r  <= S_RD2;
            end else begin
              mem_addr <= instr_addr1;
              state_r  <= S_RD1;
            end
`else
            mem_addr <= instr_addr1;
            state_r  <= S_RD1;
`endif
          end else begin
            state_r <= S_IDLE;
          end
        end

        S_RD1: begin
          if (mem_ack) begin
            instr    <= mem_rdata;
            mem_addr <= a2_r;
            cnt_r    <= '0;
            state_r  <= S_RD2;
          end else if (expire_s) begin
            mem_rd      <= 1'b0;
            instr       <= STP_WORD;
            N           <= 16'h0000;
            fetch_err   <= 1'b1;
            fetch_valid <= 1'b1;
            fetch_busy  <= 1'b0;
            state_r     <= S_IDLE;
`ifdef FETCH_REUSE_EN
            tag_v_r     <= 1'b0;
`endif
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end

        S_RD2: begin
          if (mem_ack) begin
            N           <= mem_rdata;
            mem_rd      <= 1'b0;
            fetch_valid <= 1'b1;
            fetch_busy  <= 1'b0;
            state_r     <= S_IDLE;
`ifdef FETCH_REUSE_EN
            last_a2_r   <= a2_r;
            last_n_r    <= mem_rdata;
            tag_v_r     <= 1'b1;
`endif
          end else if (expire_s) begin
            mem_rd      <= 1'b0;
            instr       <= STP_WORD;
            N           <= 16'h0000;
            fetch_err   <= 1'b1;
            fetch_valid <= 1'b1;
            fetch_busy  <= 1'b0;
            state_r     <= S_IDLE;
`ifdef FETCH_REUSE_EN
            tag_v_r     <= 1'b0;
`endif
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end

        default: begin
          // unreachable encoding: drop any read and fall back to idle
          mem_rd     <= 1'b0;
          fetch_busy <= 1'b0;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a behavioural memory.
// The memory has a per-address ack delay, a "dead" mode and a stray-ack mode.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic [15:0] instr_addr1 = 16'h0000;
  logic [15:0] instr_addr2 = 16'h0000;
  logic        fetch_busy;
  logic        fetch_valid;
  logic [15:0] instr;
  logic [15:0] N;
  logic        fetch_err;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_ack = 1'b0;

  int total = 0;
  int bad = 0;

  logic [15:0] mem [0:255];
  int          dly [0:255];
  bit          mem_dead = 1'b0;
  bit          stray_ack = 1'b0;
  int          rd_count = 0;
  logic [15:0] last_rd_addr = 16'h0000;

  bit          prev_rd_m = 1'b0;
  logic [15:0] prev_addr_m = 16'h0000;
  bit          prev_ack_m = 1'b0;
  int          wcnt = 0;
  bit          ack_now = 1'b0;

  instr_fetch dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req),
    .instr_addr1(instr_addr1), .instr_addr2(instr_addr2),
    .fetch_busy(fetch_busy), .fetch_valid(fetch_valid),
    .instr(instr), .N(N), .fetch_err(fetch_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // memory model: acks an access after dly[addr] wait cycles, updated after each edge
  always @(posedge clk) begin
    #2;
    if (mem_rd && (!prev_rd_m || mem_addr != prev_addr_m || prev_ack_m)) wcnt = 0;
    else if (mem_rd) wcnt = wcnt + 1;
    ack_now = mem_rd && !mem_dead && (wcnt == dly[mem_addr[7:0]]);
    mem_ack = ack_now || stray_ack;
    mem_rdata = mem[mem_addr[7:0]];
    if (ack_now) begin
      rd_count = rd_count + 1;
      last_rd_addr = mem_addr;
    end
    prev_rd_m = mem_rd;
    prev_addr_m = mem_addr;
    prev_ack_m = ack_now;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // issue one request and wait (bounded) for fetch_valid; lat=-1 on expiry
  task automatic do_fetch(input logic [15:0] a1, input logic [15:0] a2, input int limit,
                          input bit disturb, output int lat, output int viol);
    bit          p_rd;
    bit          p_ack;
    logic [15:0] p_addr;
    p_rd = 1'b0;
    p_ack = 1'b0;
    p_addr = 16'h0000;
    @(negedge clk);
    instr_addr1 = a1;
    instr_addr2 = a2;
    fetch_req = 1'b1;
    @(posedge clk);
    #1 fetch_req = 1'b0;
    lat = -1;
    viol = 0;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (disturb && n == 1) begin
        fetch_req = 1'b1;
        instr_addr1 = 16'h0060;
        instr_addr2 = 16'h0061;
      end
      if (disturb && n == 2) fetch_req = 1'b0;
      if (n == 1) check("busy_after_accept", {31'd0, fetch_busy}, 32'd1);
      if (p_rd && mem_rd && !p_ack && mem_addr != p_addr) viol = viol + 1;
      p_rd = mem_rd;
      p_ack = mem_ack;
      p_addr = mem_addr;
      if (fetch_valid) begin
        lat = n;
        check("busy_at_valid", {31'd0, fetch_busy}, 32'd0);
        break;
      end
    end
    fetch_req = 1'b0;
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (fetch_valid) cnt = cnt + 1;
    end
  endtask

  int lat;
  int viol;
  int nv;
  int rc0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'(i) ^ 16'hA500;
      dly[i] = 0;
    end
    mem[8'h10] = 16'h4801;  mem[8'h11] = 16'h0005;
    mem[8'h30] = 16'h1234;  mem[8'h31] = 16'hBEEF;
    dly[8'h30] = 4;         dly[8'h31] = 2;
    mem[8'h50] = 16'h5050;  mem[8'h51] = 16'h5151;
    dly[8'h50] = 3;
    mem[8'h60] = 16'h6060;  mem[8'h61] = 16'h6161;
    mem[8'h70] = 16'h7777;  mem[8'h71] = 16'h7171;
    dly[8'h71] = 5;
    mem[8'h20] = 16'h2020;  mem[8'h21] = 16'h2121;  mem[8'h22] = 16'h2222;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_instr", {16'd0, instr}, 32'd0);
    check("rst_N", {16'd0, N}, 32'd0);
    check("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_busy", {31'd0, fetch_busy}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // zero-wait fetch
    do_fetch(16'h0010, 16'h0011, 30, 1'b0, lat, viol);
    check("zw_latency", lat, 32'd3);
    check("zw_instr", {16'd0, instr}, 32'h4801);
    check("zw_N", {16'd0, N}, 32'h0005);
    check("zw_err", {31'd0, fetch_err}, 32'd0);

    // wait states 4 / 2
    do_fetch(16'h0030, 16'h0031, 30, 1'b0, lat, viol);
    check("ws_latency", lat, 32'd9);
    check("ws_addr_stable", viol, 32'd0);
    check("ws_instr", {16'd0, instr}, 32'h1234);
    check("ws_N", {16'd0, N}, 32'hBEEF);
    check("ws_err", {31'd0, fetch_err}, 32'd0);

    // timeout: memory never acks
    mem_dead = 1'b1;
    do_fetch(16'h0040, 16'h0041, 40, 1'b0, lat, viol);
    check("to_latency", lat, 32'd17);
    check("to_instr", {16'd0, instr}, 32'hF800);
    check("to_N", {16'd0, N}, 32'h0000);
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check("to_mem_rd_low", {31'd0, mem_rd}, 32'd0);
    @(negedge clk);
    check("to_err_held", {31'd0, fetch_err}, 32'd1);
    check("to_mem_rd_still_low", {31'd0, mem_rd}, 32'd0);
    mem_dead = 1'b0;
    do_fetch(16'h0010, 16'h0011, 30, 1'b0, lat, viol);
    check("to_next_latency", lat, 32'd3);
    check("to_err_cleared", {31'd0, fetch_err}, 32'd0);
    check("to_next_instr", {16'd0, instr}, 32'h4801);

    // stray acks in idle are ignored
    @(negedge clk);
    stray_ack = 1'b1;
    count_valids(3, nv);
    stray_ack = 1'b0;
    check("stray_ack_no_valid", nv, 32'd0);
    check("stray_ack_no_rd", {31'd0, mem_rd}, 32'd0);
    count_valids(2, nv);

    // fetch_req and address changes while busy are ignored
    do_fetch(16'h0050, 16'h0051, 30, 1'b1, lat, viol);
    check("busy_latency", lat, 32'd6);
    check("busy_instr", {16'd0, instr}, 32'h5050);
    check("busy_N", {16'd0, N}, 32'h5151);
    count_valids(8, nv);
    check("busy_single_valid", nv, 32'd0);

    // reset during RD2
    @(negedge clk);
    instr_addr1 = 16'h0070;
    instr_addr2 = 16'h0071;
    fetch_req = 1'b1;
    @(posedge clk);
    #1 fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rr_in_rd2_addr", {16'd0, mem_addr}, 32'h0071);
    check("rr_in_rd2_instr", {16'd0, instr}, 32'h7777);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rr_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rr_instr", {16'd0, instr}, 32'd0);
    check("rr_N", {16'd0, N}, 32'd0);
    check("rr_busy", {31'd0, fetch_busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_valids(12, nv);
    check("rr_no_valid", nv, 32'd0);
    do_fetch(16'h0010, 16'h0011, 30, 1'b0, lat, viol);
    check("rr_after_latency", lat, 32'd3);
    check("rr_after_N", {16'd0, N}, 32'h0005);

    // back-to-back fetches where addr1 equals the previous addr2
    do_fetch(16'h0020, 16'h0021, 30, 1'b0, lat, viol);
    check("ru_first_latency", lat, 32'd3);
    rc0 = rd_count;
    do_fetch(16'h0021, 16'h0022, 30, 1'b0, lat, viol);
`ifdef FETCH_REUSE_EN
    check("ru_latency", lat, 32'd2);
    check("ru_reads", rd_count - rc0, 32'd1);
`else
    check("ru_latency", lat, 32'd3);
    check("ru_reads", rd_count - rc0, 32'd2);
`endif
    check("ru_last_read_addr", {16'd0, last_rd_addr}, 32'h0022);
    check("ru_instr", {16'd0, instr}, 32'h2121);
    check("ru_N", {16'd0, N}, 32'h2222);
    check("ru_err", {31'd0, fetch_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
